cp0_fwd_tracker: RTL and testbench

Parametrised CP0 forwarding and hazard tracker for the MIPS pipeline. It follows in-flight MTC0 writes through DEPTH post-ID stages (EX first, then MEM, and so on) in an internal shift register. It forwards the youngest matching write to a CP0 read in ID, whether MFC0 on any cs/sel or ERET on EPC. Writes retire when they leave the last stage, where the CP0 register file has been updated. It sits beside the ID/EX hazard logic and drives the CP0 read-data mux select.

---
 rtl/cp0_fwd_tracker.sv | 122 ++++++++++++
 tb/tb_cp0_fwd_tracker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_fwd_tracker.sv
// cp0_fwd_tracker: follows in-flight MTC0 writes through the post-ID stages
// and forwards the youngest matching write to an MFC0/ERET read in ID.
// Entry 0 is EX, and its data is taken live from ex_wdata. Entries 1..DEPTH-1
// hold captured copies of that data until the write retires.
module cp0_fwd_tracker #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int FW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [2:0]       id_cp0Op,
  input  logic [4:0]       id_cs,
  input  logic [2:0]       id_sel,
  input  logic             stall,
  input  logic             freeze,
  input  logic             flush,
  input  logic [DW-1:0]    ex_wdata,
  output logic [FW-1:0]    cp0Forward,
  output logic [DW-1:0]    fwd_data,
  output logic [DEPTH-1:0] inflight
);

  localparam logic [2:0] OP_MFC0    = 3'b001;
  localparam logic [2:0] OP_MTC0    = 3'b010;
  localparam logic [2:0] OP_SYSCALL = 3'b011;
  localparam logic [2:0] OP_ERET    = 3'b100;

  // EPC lives at cs=14, sel=0; ERET reads it implicitly
  localparam logic [4:0] EPC_CS  = 5'd14;
  localparam logic [2:0] EPC_SEL = 3'd0;

  // Flattened view of every entry, used by the match search
  logic [DEPTH-1:0] ent_v;
  logic [4:0]       ent_cs   [DEPTH];
  logic [2:0]       ent_sel  [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic       v_q;
      logic [4:0] cs_q;
      logic [2:0] sel_q;

      if (gi == 0) begin : g_ex
        // EX entry: loads the ID instruction on advance, becomes a bubble on
        // stall, and is cleared by flush even while frozen
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_q   <= 1'b0;
            cs_q  <= '0;
            sel_q <= '0;
          end else if (freeze) begin
            if (flush) v_q <= 1'b0;
          end else begin
            v_q   <= id_valid && (id_cp0Op == OP_MTC0) && !flush && !stall;
            cs_q  <= id_cs;
            sel_q <= id_sel;
          end
        end

        assign ent_data[gi] = ex_wdata;
      end else begin : g_post
        logic [DW-1:0] data_q;

        // Later entries shift whenever the pipeline is not frozen; a stall only
        // holds ID, so the EX write still moves on (with its live data captured)
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_q    <= 1'b0;
            cs_q   <= '0;
            sel_q  <= '0;
            data_q <= '0;
          end else if (!freeze) begin
            v_q    <= ent_v[gi-1];
            cs_q   <= ent_cs[gi-1];
            sel_q  <= ent_sel[gi-1];
            data_q <= ent_data[gi-1];
          end
        end

        assign ent_data[gi] = data_q;
      end

      assign ent_v[gi]   = v_q;
      assign ent_cs[gi]  = cs_q;
      assign ent_sel[gi] = sel_q;
    end
  endgenerate

  assign inflight = ent_v;

  logic [4:0] key_cs;
  logic [2:0] key_sel;
  logic       is_read;
  logic       hit;

  assign is_read = id_valid && ((id_cp0Op == OP_MFC0) || (id_cp0Op == OP_ERET));
  assign key_cs  = (id_cp0Op == OP_ERET) ? EPC_CS  : id_cs;
  assign key_sel = (id_cp0Op == OP_ERET) ? EPC_SEL : id_sel;

  // Youngest-first search: the first valid entry with a matching key wins
  always_comb begin
    cp0Forward = '0;
    fwd_data   = '0;
    hit        = 1'b0;
    if (id_valid && (id_cp0Op == OP_SYSCALL)) begin
      cp0Forward = '1;
    end else if (is_read) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit && ent_v[k] && (ent_cs[k] == key_cs) && (ent_sel[k] == key_sel)) begin
          hit        = 1'b1;
          cp0Forward = FW'(k + 1);
          fwd_data   = ent_data[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_fwd_tracker.sv
// Testbench for cp0_fwd_tracker (DEPTH=2, DW=32, FW=3): a table of per-cycle
// vectors with expected outputs queued as a scoreboard, plus a hand-written
// asynchronous-reset sequence.
module tb_cp0_fwd_tracker;

  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int FW    = 3;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] MFC0 = 3'b001;
  localparam logic [2:0] MTC0 = 3'b010;
  localparam logic [2:0] SYSC = 3'b011;
  localparam logic [2:0] ERET = 3'b100;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [2:0]       id_cp0Op;
  logic [4:0]       id_cs;
  logic [2:0]       id_sel;
  logic             stall;
  logic             freeze;
  logic             flush;
  logic [DW-1:0]    ex_wdata;
  logic [FW-1:0]    cp0Forward;
  logic [DW-1:0]    fwd_data;
  logic [DEPTH-1:0] inflight;

  cp0_fwd_tracker #(.DEPTH(DEPTH), .DW(DW), .FW(FW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_cp0Op   (id_cp0Op),
    .id_cs      (id_cs),
    .id_sel     (id_sel),
    .stall      (stall),
    .freeze     (freeze),
    .flush      (flush),
    .ex_wdata   (ex_wdata),
    .cp0Forward (cp0Forward),
    .fwd_data   (fwd_data),
    .inflight   (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic [2:0]       op;
    logic [4:0]       cs;
    logic [2:0]       sel;
    logic             stall;
    logic             freeze;
    logic             flush;
    logic [DW-1:0]    wdata;
    logic [FW-1:0]    e_fwd;
    logic [DW-1:0]    e_data;
    logic [DEPTH-1:0] e_infl;
  } vec_t;

  typedef struct {
    logic [FW-1:0]    fwd;
    logic [DW-1:0]    data;
    logic [DEPTH-1:0] infl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [4:0] cs,
                              input logic [2:0] sel, input logic st, input logic fr,
                              input logic fl, input logic [DW-1:0] wd,
                              input logic [FW-1:0] ef, input logic [DW-1:0] ed,
                              input logic [DEPTH-1:0] ei);
    vec_t r;
    r.valid = v;  r.op = op;  r.cs = cs;  r.sel = sel;
    r.stall = st; r.freeze = fr; r.flush = fl; r.wdata = wd;
    r.e_fwd = ef; r.e_data = ed; r.e_infl = ei;
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_cp0Op = v.op; id_cs = v.cs; id_sel = v.sel;
    stall = v.stall; freeze = v.freeze; flush = v.flush; ex_wdata = v.wdata;
  endtask

  // Drive one cycle's inputs, queue its expectation, compare at the falling
  // edge, then let the rising edge update the tracker.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e, got;
    drive(v);
    e.fwd = v.e_fwd; e.data = v.e_data; e.infl = v.e_infl;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check($sformatf("v%0d.cp0Forward", idx), DW'(cp0Forward), DW'(got.fwd));
    check($sformatf("v%0d.fwd_data", idx), fwd_data, got.data);
    check($sformatf("v%0d.inflight", idx), DW'(inflight), DW'(got.infl));
    $display("vec %0d: op=%0d cs=%0d sel=%0d st=%0b fr=%0b fl=%0b wd=%0h -> fwd=%0d data=%0h infl=%b",
             idx, v.op, v.cs, v.sel, v.stall, v.freeze, v.flush, v.wdata,
             cp0Forward, fwd_data, inflight);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(mk(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //          v  op    cs  sel st fr fl wdata          fwd data           infl
    // Empty tracker, ERET
    vecs.push_back(mk(1, ERET, 3, 5, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));
    // EPC write: forwarded from EX, then from entry 1, then retired
    vecs.push_back(mk(1, MTC0, 14, 0, 0, 0, 0, 32'h0,       0, 32'h0,        2'b00));
    vecs.push_back(mk(1, ERET, 3, 5, 0, 0, 0, 32'h8000_0180, 1, 32'h8000_0180, 2'b01));
    vecs.push_back(mk(1, ERET, 0, 0, 0, 0, 0, 32'hDEAD,     2, 32'h8000_0180, 2'b10));
    vecs.push_back(mk(1, ERET, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));
    // Back-to-back writes to cs=12: younger wins, then older-position data
    vecs.push_back(mk(1, MTC0, 12, 0, 0, 0, 0, 32'h0,       0, 32'h0,        2'b00));
    vecs.push_back(mk(1, MTC0, 12, 0, 0, 0, 0, 32'h11,      0, 32'h0,        2'b01));
    vecs.push_back(mk(1, MFC0, 12, 0, 0, 0, 0, 32'h22,      1, 32'h22,       2'b11));
    vecs.push_back(mk(1, MFC0, 12, 0, 0, 0, 0, 32'h99,      2, 32'h22,       2'b10));
    vecs.push_back(mk(1, MFC0, 12, 0, 0, 0, 0, 32'h0,       0, 32'h0,        2'b00));
    // cs=14 sel=1 must not satisfy ERET, but does satisfy MFC0 14/1
    vecs.push_back(mk(1, MTC0, 14, 1, 0, 0, 0, 32'h0,       0, 32'h0,        2'b00));
    vecs.push_back(mk(1, ERET, 0, 0, 0, 0, 0, 32'h55,       0, 32'h0,        2'b01));
    vecs.push_back(mk(1, MFC0, 14, 1, 0, 0, 0, 32'h66,      2, 32'h55,       2'b10));
    vecs.push_back(mk(1, NOP,  0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));
    // Flushed MTC0 never enters
    vecs.push_back(mk(1, MTC0, 3, 0, 0, 0, 1, 32'h0,        0, 32'h0,        2'b00));
    vecs.push_back(mk(1, MFC0, 3, 0, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));
    // Freeze holds an entry-1 write for three cycles
    vecs.push_back(mk(1, MTC0, 9, 2, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));
    vecs.push_back(mk(1, NOP,  9, 2, 0, 0, 0, 32'h77,       0, 32'h0,        2'b01));
    vecs.push_back(mk(1, MFC0, 9, 2, 0, 1, 0, 32'h88,       2, 32'h77,       2'b10));
    vecs.push_back(mk(1, MFC0, 9, 2, 0, 1, 0, 32'h88,       2, 32'h77,       2'b10));
    vecs.push_back(mk(1, MFC0, 9, 2, 0, 1, 0, 32'h88,       2, 32'h77,       2'b10));
    vecs.push_back(mk(1, MFC0, 9, 2, 0, 0, 0, 32'h88,       2, 32'h77,       2'b10));
    vecs.push_back(mk(1, MFC0, 9, 2, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));
    // Stall: entry 0 becomes a bubble but its data still moves to entry 1
    vecs.push_back(mk(1, MTC0, 5, 0, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));
    vecs.push_back(mk(1, MFC0, 5, 0, 1, 0, 0, 32'hA5,       1, 32'hA5,       2'b01));
    vecs.push_back(mk(1, MFC0, 5, 0, 0, 0, 0, 32'h0,        2, 32'hA5,       2'b10));
    vecs.push_back(mk(1, NOP,  0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));
    // Freeze + flush: entry 1 holds, entry 0 clears
    vecs.push_back(mk(1, MTC0, 6, 0, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));
    vecs.push_back(mk(1, MTC0, 7, 0, 0, 0, 0, 32'h61,       0, 32'h0,        2'b01));
    vecs.push_back(mk(1, MFC0, 6, 0, 0, 1, 1, 32'h71,       2, 32'h61,       2'b11));
    vecs.push_back(mk(1, MFC0, 7, 0, 0, 0, 0, 32'h71,       0, 32'h0,        2'b10));
    vecs.push_back(mk(1, MFC0, 6, 0, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));
    // SYSCALL overrides any match; invalid ID never forwards
    vecs.push_back(mk(1, MTC0, 14, 0, 0, 0, 0, 32'h0,       0, 32'h0,        2'b00));
    vecs.push_back(mk(1, SYSC, 14, 0, 0, 0, 0, 32'h1234,    3'b111, 32'h0,   2'b01));
    vecs.push_back(mk(0, ERET, 0, 0, 0, 0, 0, 32'h1,        0, 32'h0,        2'b10));
    vecs.push_back(mk(0, SYSC, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        2'b00));

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of a cycle with a write in flight
    run_vec(100, mk(1, MTC0, 14, 0, 0, 0, 0, 32'h0, 0, 32'h0, 2'b00));
    drive(mk(1, ERET, 0, 0, 0, 0, 0, 32'hCAFE, 0, 0, 0));
    @(negedge clk);
    check("rst.pre_fwd", DW'(cp0Forward), DW'(3'd1));
    check("rst.pre_data", fwd_data, 32'hCAFE);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.async_fwd", DW'(cp0Forward), 32'h0);
    check("rst.async_data", fwd_data, 32'h0);
    check("rst.async_infl", DW'(inflight), 32'h0);
    $display("async reset: fwd=%0d data=%0h infl=%b", cp0Forward, fwd_data, inflight);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(101, mk(1, ERET, 0, 0, 0, 0, 0, 32'hCAFE, 0, 32'h0, 2'b00));
    run_vec(102, mk(1, ERET, 0, 0, 0, 0, 0, 32'hCAFE, 0, 32'h0, 2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
